// File: rtl/aclock_cfg_seq.sv
// ---------------------------------------------------------------------------
// aclock_cfg_seq -- configuration / snooze sequencer for an alarm-clock core.
//
// Accepts set-time / set-alarm requests over a valid/ready handshake, checks
// the requested BCD hh:mm, and drives the clock core's load bus and load
// strobes. When the alarm is ringing and the snooze button is pressed, it
// silences the alarm with a one-cycle STOP_al strobe. With ACLK_SNOOZE_EN
// defined it then reloads the alarm at current time + SNOOZE_MIN minutes.
// Without ACLK_SNOOZE_EN the sequencer only silences the alarm.
//
// Parameters
//   SNOOZE_MIN  snooze interval in minutes (1..9)
//   LD_CYCLES   number of cycles a load strobe is held (1..15)
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   cfg_valid / cfg_ready          request handshake
//   cfg_kind                       0 = set time, 1 = set alarm
//   cfg_h1/h0/m1/m0                requested BCD hh:mm
//   cfg_done / cfg_err             one-cycle completion / rejection pulses
//   al_off                         pulse, disarms the alarm (AL_ON -> 0)
//   snz_req                        snooze button (level)
//   Alarm                          alarm ringing, from the clock core
//   H_out1/H_out0/M_out1/M_out0    current BCD time from the clock core
//   H_in1/H_in0/M_in1/M_in0        BCD load value to the clock core
//   LD_time / LD_alarm             load strobes to the clock core
//   STOP_al                        alarm silence strobe
//   AL_ON                          alarm arm enable
// ---------------------------------------------------------------------------
module aclock_cfg_seq #(
    parameter int SNOOZE_MIN = 5,
    parameter int LD_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_kind,
    input  logic [1:0] cfg_h1,
    input  logic [3:0] cfg_h0,
    input  logic [3:0] cfg_m1,
    input  logic [3:0] cfg_m0,
    output logic       cfg_done,
    output logic       cfg_err,
    input  logic       al_off,
    input  logic       snz_req,
    input  logic       Alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON
);

    // Load counter value for the final strobe cycle is zero; start value:
    localparam logic [3:0] LD_START = 4'(LD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STOP  = 3'd3
`ifdef ACLK_SNOOZE_EN
        ,
        ST_CALC  = 3'd4
`endif
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        kind_reg;        // 0 = time load, 1 = alarm load
    logic [13:0] cap_time_reg;    // captured request {h1,h0,m1,m0}
    logic [13:0] hin_reg;         // value presented on H_in*/M_in*
    logic [3:0]  ld_cnt_reg;      // strobe cycles remaining after this one
    logic        done_reg;
    logic        al_on_reg;
    logic        armed_reg;       // snooze may fire for the current Alarm
    logic        ready_en_reg;    // low until the first edge after reset

    logic        snz_hit;
    logic        snz_fire;
    logic        cfg_accept;
    logic        cap_ok;
    logic        ld_last;

    logic [1:0]  cap_h1;
    logic [3:0]  cap_h0;
    logic [3:0]  cap_m1;
    logic [3:0]  cap_m0;

    assign cap_h1 = cap_time_reg[13:12];
    assign cap_h0 = cap_time_reg[11:8];
    assign cap_m1 = cap_time_reg[7:4];
    assign cap_m0 = cap_time_reg[3:0];

    // Legal BCD time: every digit a decimal digit, hh <= 23, mm <= 59.
    assign cap_ok = (cap_h0 <= 4'd9) && (cap_m0 <= 4'd9) && (cap_m1 <= 4'd5) &&
                    ((cap_h1 < 2'd2) || ((cap_h1 == 2'd2) && (cap_h0 <= 4'd3)));

    // A ringing alarm with the button down blocks configuration even when
    // the snooze for this ring has already been used.
    assign snz_hit    = snz_req & Alarm;
    assign snz_fire   = (state_reg == ST_IDLE) & snz_hit & armed_reg;
    assign cfg_accept = cfg_valid & cfg_ready;
    assign ld_last    = (ld_cnt_reg == 4'd0);

`ifdef ACLK_SNOOZE_EN
    // Snooze target: current time + SNOOZE_MIN, digit by digit in BCD.
    logic [4:0]  snz_m0_sum;
    logic        snz_m0_carry;
    logic [3:0]  snz_m0;
    logic [3:0]  snz_m1_inc;
    logic        snz_m1_carry;
    logic [3:0]  snz_m1;
    logic [1:0]  snz_h1;
    logic [3:0]  snz_h0;
    logic [13:0] snz_time;

    always_comb begin
        snz_m0_sum   = {1'b0, M_out0} + 5'(SNOOZE_MIN);
        snz_m0_carry = (snz_m0_sum >= 5'd10);
        snz_m0       = snz_m0_carry ? 4'(snz_m0_sum - 5'd10) : snz_m0_sum[3:0];
        snz_m1_inc   = M_out1 + {3'd0, snz_m0_carry};
        snz_m1_carry = (snz_m1_inc >= 4'd6);
        snz_m1       = snz_m1_carry ? 4'd0 : snz_m1_inc;
        snz_h1       = H_out1;
        snz_h0       = H_out0;
        if (snz_m1_carry) begin
            if ((H_out1 == 2'd2) && (H_out0 >= 4'd3)) begin
                // 23:5x rolls over midnight
                snz_h1 = 2'd0;
                snz_h0 = 4'd0;
            end else if (H_out0 >= 4'd9) begin
                snz_h1 = H_out1 + 2'd1;
                snz_h0 = 4'd0;
            end else begin
                snz_h0 = H_out0 + 4'd1;
            end
        end
        snz_time = {snz_h1, snz_h0, snz_m1, snz_m0};
    end
`else
    // Current time and snooze length are only needed for the alarm reload.
    logic snooze_unused;
    assign snooze_unused = ^{H_out1, H_out0, M_out1, M_out0, 4'(SNOOZE_MIN)};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (snz_fire) begin
                    state_next = ST_STOP;
                end else if (cfg_accept) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = cap_ok ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                if (ld_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STOP: begin
`ifdef ACLK_SNOOZE_EN
                state_next = ST_CALC;
`else
                state_next = ST_IDLE;
`endif
            end
`ifdef ACLK_SNOOZE_EN
            ST_CALC: begin
                state_next = ST_LOAD;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Strobes decode straight from the state register so an asynchronous
    // reset drops them without waiting for a clock edge.
    always_comb begin
        cfg_ready = ready_en_reg & (state_reg == ST_IDLE) & ~snz_hit;
        cfg_err   = (state_reg == ST_CHECK) & ~cap_ok;
        LD_time   = (state_reg == ST_LOAD) & ~kind_reg;
        LD_alarm  = (state_reg == ST_LOAD) & kind_reg;
        STOP_al   = (state_reg == ST_STOP);
        cfg_done  = done_reg;
        AL_ON     = al_on_reg;
        H_in1     = hin_reg[13:12];
        H_in0     = hin_reg[11:8];
        M_in1     = hin_reg[7:4];
        M_in0     = hin_reg[3:0];
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_reg     <= 1'b0;
            cap_time_reg <= '0;
            hin_reg      <= '0;
            ld_cnt_reg   <= '0;
            done_reg     <= 1'b0;
            al_on_reg    <= 1'b0;
            armed_reg    <= 1'b1;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;

            if (cfg_accept) begin
                kind_reg     <= cfg_kind;
                cap_time_reg <= {cfg_h1, cfg_h0, cfg_m1, cfg_m0};
            end

            if ((state_reg == ST_CHECK) && cap_ok) begin
                hin_reg    <= cap_time_reg;
                ld_cnt_reg <= LD_START;
            end

`ifdef ACLK_SNOOZE_EN
            if (snz_fire) begin
                kind_reg <= 1'b1;
            end
            if (state_reg == ST_CALC) begin
                hin_reg    <= snz_time;
                ld_cnt_reg <= LD_START;
            end
`endif

            if ((state_reg == ST_LOAD) && !ld_last) begin
                ld_cnt_reg <= ld_cnt_reg - 4'd1;
            end

            done_reg <= (state_reg == ST_LOAD) & ld_last;

            // al_off beats a coincident alarm-load completion
            if (al_off) begin
                al_on_reg <= 1'b0;
            end else if ((state_reg == ST_LOAD) && ld_last && kind_reg) begin
                al_on_reg <= 1'b1;
            end

            // One snooze per ring: re-armed only once Alarm has dropped.
            if (snz_fire) begin
                armed_reg <= 1'b0;
            end else if (!Alarm) begin
                armed_reg <= 1'b1;
            end
        end
    end

endmodule
